// File: rtl/param_datapath.sv
// param_datapath: multi-cycle register-file datapath with a four-state sequencer
// (IDLE -> DECODE -> EXECUTE -> WRITEBACK). It retires one 16-bit instruction
// every four cycles.
// Optional feature: define DP_SHIFTER_EN to build the opcode 1000 shifter
// (LSH/LSHI). Without it, opcode 1000 decodes as illegal.
module param_datapath #(
  parameter int WIDTH = 16,
  parameter int NREGS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic             done,
  output logic             illegal,
  output logic [4:0]       flags,
  output logic [WIDTH-1:0] pc,
  input  logic [3:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam logic [3:0] OP_REG   = 4'b0000;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] C_ADD    = 4'b0101;
  localparam logic [3:0] C_SUB    = 4'b1001;
  localparam logic [3:0] C_CMP    = 4'b1011;
  localparam logic [3:0] C_AND    = 4'b0001;
  localparam logic [3:0] C_OR     = 4'b0010;
  localparam logic [3:0] C_XOR    = 4'b0011;
  localparam logic [3:0] C_MOV    = 4'b1101;
`ifdef DP_SHIFTER_EN
  localparam logic [3:0] X_LSH    = 4'b0100;
`endif

  // Bit positions inside the {C,L,F,Z,N} status word
  localparam int FC = 4;
  localparam int FL = 3;
  localparam int FF = 2;
  localparam int FZ = 1;
  localparam int FN = 0;

  typedef enum logic [1:0] {IDLE, DECODE, EXECUTE, WRITEBACK} state_t;

  state_t                   state;
  logic [15:0]              ir_p0;
  // Sized for the full 4-bit address space; entries at or above NREGS are never
  // written, so they stay at zero.
  logic [WIDTH-1:0]         regs [16];
  logic signed [WIDTH-1:0]  a_p1;
  logic signed [WIDTH-1:0]  b_p1;
  logic [WIDTH-1:0]         res_p2;
  logic [4:0]               flg_p2;

  logic [3:0]       opc, rd, ext, rs, code;
  logic             is_reg, rd_ok, rs_ok, legal, wr_en;
  logic [WIDTH-1:0] b_sel, res_nxt;
  logic [4:0]       flg_nxt;
  logic [WIDTH:0]   sum, diff;

  function automatic logic is_alu(input logic [3:0] c);
    return c inside {C_ADD, C_SUB, C_CMP, C_AND, C_OR, C_XOR, C_MOV};
  endfunction

`ifdef DP_SHIFTER_EN
  // Positive amount shifts left; negative shifts logically right; too far gives 0
  function automatic logic [WIDTH-1:0] shift_fn(input logic [WIDTH-1:0] v,
                                                input logic signed [5:0] amt);
    logic [5:0] mag;
    mag = amt[5] ? -amt : amt;
    if (int'(mag) >= WIDTH) return '0;
    return amt[5] ? (v >> mag) : (v << mag);
  endfunction
`endif

  assign opc    = ir_p0[15:12];
  assign rd     = ir_p0[11:8];
  assign ext    = ir_p0[7:4];
  assign rs     = ir_p0[3:0];
  assign is_reg = (opc == OP_REG);
  assign code   = is_reg ? ext : opc;
  assign rd_ok  = ({1'b0, rd} < 5'(NREGS));
  assign rs_ok  = ({1'b0, rs} < 5'(NREGS));
  assign wr_en  = legal && (code != C_CMP);

  assign instr_ready = (state == IDLE);
  assign dbg_data    = ({1'b0, dbg_addr} < 5'(NREGS)) ? regs[dbg_addr] : '0;

  // Decide whether the held instruction is a supported opcode/ext with valid registers
  always_comb begin
    legal = 1'b0;
    if (rd_ok) begin
      if (is_reg) legal = is_alu(ext) && rs_ok;
      else if (is_alu(opc)) legal = 1'b1;
`ifdef DP_SHIFTER_EN
      else if (opc == OP_SHIFT) legal = (ext == X_LSH) ? rs_ok : (ext[3:1] == 3'b000);
`endif
    end
  end

  // Second operand: register, sign-extended imm8 (arith/MOV) or zero-extended imm8 (logical)
  always_comb begin
    if (is_reg || (opc == OP_SHIFT))
      b_sel = regs[rs];
    else if (code inside {C_ADD, C_SUB, C_CMP, C_MOV})
      b_sel = {{(WIDTH-8){ir_p0[7]}}, ir_p0[7:0]};
    else
      b_sel = {{(WIDTH-8){1'b0}}, ir_p0[7:0]};
  end

  assign sum  = {1'b0, a_p1} + {1'b0, b_p1};
  assign diff = {1'b0, a_p1} - {1'b0, b_p1};

  // ALU result and updated status word for the operands latched in DECODE
  always_comb begin
    res_nxt = a_p1;
    flg_nxt = flags;
    case (code)
      C_ADD: begin
        res_nxt     = sum[WIDTH-1:0];
        flg_nxt[FC] = sum[WIDTH];
        flg_nxt[FF] = (a_p1[WIDTH-1] == b_p1[WIDTH-1]) && (sum[WIDTH-1] != a_p1[WIDTH-1]);
      end
      C_SUB: begin
        res_nxt     = diff[WIDTH-1:0];
        flg_nxt[FC] = diff[WIDTH];
        flg_nxt[FF] = (a_p1[WIDTH-1] != b_p1[WIDTH-1]) && (diff[WIDTH-1] != a_p1[WIDTH-1]);
      end
      C_CMP: begin
        flg_nxt[FZ] = (a_p1 == b_p1);
        flg_nxt[FL] = ($unsigned(a_p1) < $unsigned(b_p1));
        flg_nxt[FN] = (a_p1 < b_p1);
      end
      C_AND: res_nxt = a_p1 & b_p1;
      C_OR:  res_nxt = a_p1 | b_p1;
      C_XOR: res_nxt = a_p1 ^ b_p1;
      C_MOV: res_nxt = b_p1;
`ifdef DP_SHIFTER_EN
      OP_SHIFT: res_nxt = shift_fn(a_p1, (ext == X_LSH) ? b_p1[5:0] : {ir_p0[4], ir_p0[4:0]});
`endif
      default: ;
    endcase
  end

  // Datapath registers: instruction capture, operand fetch, execute result
  always_ff @(posedge clk) begin
    // p0: instruction register, loaded only on an accepted handshake
    if (state == IDLE && instr_valid) ir_p0 <= instr;
    // p1: operands read before any write of this instruction (Rdest==Rsrc safe)
    if (state == DECODE) begin
      a_p1 <= regs[rd];
      b_p1 <= b_sel;
    end
    // p2: result and candidate status word
    if (state == EXECUTE) begin
      res_p2 <= res_nxt;
      flg_p2 <= flg_nxt;
    end
  end

  // Sequencer plus architectural state (register file, PSR, pc) and retire pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      done    <= 1'b0;
      illegal <= 1'b0;
      flags   <= '0;
      pc      <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE:    if (instr_valid) state <= DECODE;
        DECODE:  state <= EXECUTE;
        EXECUTE: begin
          state   <= WRITEBACK;
          done    <= 1'b1;
          illegal <= !legal;
        end
        WRITEBACK: begin
          if (wr_en) regs[rd] <= res_p2;
          if (legal) flags <= flg_p2;
          pc    <= pc + WIDTH'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_datapath.sv
// Testbench for param_datapath (WIDTH=16, NREGS=8). A directed table is followed
// by handshake/reset sequences and randomized instructions, which are checked
// against an arithmetic reference model. Honours DP_SHIFTER_EN when defined.
module tb_param_datapath;

  localparam int W     = 16;
  localparam int NR    = 8;
  localparam int MASK  = (1 << W) - 1;
  localparam int SMAX  = (1 << (W - 1)) - 1;
  localparam int SMIN  = -(1 << (W - 1));
`ifdef DP_SHIFTER_EN
  localparam bit SHIFTER = 1'b1;
`else
  localparam bit SHIFTER = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  instr = '0;
  logic         instr_valid = 1'b0;
  logic         instr_ready, done, illegal;
  logic [4:0]   flags;
  logic [W-1:0] pc;
  logic [3:0]   dbg_addr = '0;
  logic [W-1:0] dbg_data;

  param_datapath #(.WIDTH(W), .NREGS(NR)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .done(done), .illegal(illegal), .flags(flags),
    .pc(pc), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #25 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  int mr [16];
  int mflags;
  int mpc;

  typedef struct {
    logic [15:0] ins;
    logic [15:0] val;
    logic [4:0]  fl;
    bit          ill;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [15:0] ins, input logic [15:0] val,
                     input logic [4:0] fl, input bit ill);
    vec_t v;
    v.ins = ins; v.val = val; v.fl = fl; v.ill = ill;
    tbl.push_back(v);
  endtask

  function automatic int sx(input int v, input int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  function automatic bit alu_code(input int v);
    return v == 1 || v == 2 || v == 3 || v == 5 || v == 9 || v == 11 || v == 13;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mr[i] = 0;
    mflags = 0;
    mpc = 0;
  endtask

  // Applies one instruction to the model; returns 1 if it is illegal
  function automatic bit model_step(input logic [15:0] ins);
    int opc, rd, ext, rs, code, a, b, sa, sb, res, amt;
    bit legal, isimm, c, l, f, z, n;
    opc = int'(ins[15:12]); rd = int'(ins[11:8]);
    ext = int'(ins[7:4]);   rs = int'(ins[3:0]);
    isimm = (opc != 0);
    code = isimm ? opc : ext;
    legal = 1'b0;
    mpc = (mpc + 1) & MASK;
    if (rd < NR) begin
      if (!isimm) legal = alu_code(ext) && (rs < NR);
      else if (alu_code(opc)) legal = 1'b1;
      else if (opc == 8 && SHIFTER) legal = (ext == 4) ? (rs < NR) : (ext <= 1);
    end
    if (!legal) return 1'b1;
    c = mflags[4]; l = mflags[3]; f = mflags[2]; z = mflags[1]; n = mflags[0];
    a = mr[rd];
    if (!isimm || opc == 8) b = mr[rs];
    else if (code == 1 || code == 2 || code == 3) b = int'(ins[7:0]);
    else b = sx(int'(ins[7:0]), 8) & MASK;
    sa = sx(a, W);
    sb = sx(b, W);
    res = a;
    case (code)
      5: begin
        res = (a + b) & MASK; c = (a + b) > MASK;
        f = (sa + sb > SMAX) || (sa + sb < SMIN);
      end
      9: begin
        res = (a - b) & MASK; c = a < b;
        f = (sa - sb > SMAX) || (sa - sb < SMIN);
      end
      11: begin z = (a == b); l = (a < b); n = (sa < sb); end
      1: res = a & b;
      2: res = a | b;
      3: res = a ^ b;
      13: res = b;
      8: begin
        amt = (ext == 4) ? sx(b & 63, 6) : sx(int'(ins[4:0]), 5);
        if (amt >= 0) res = (amt >= W) ? 0 : (a << amt) & MASK;
        else res = (-amt >= W) ? 0 : a >> (-amt);
      end
      default: ;
    endcase
    mflags = (int'(c) << 4) | (int'(l) << 3) | (int'(f) << 2) | (int'(z) << 1) | int'(n);
    if (code != 11) mr[rd] = res;
    return 1'b0;
  endfunction

  task automatic do_reset();
    instr_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Issues one instruction and checks the handshake/retire timing; returns in IDLE
  task automatic run_instr(input logic [15:0] ins, input bit exp_ill, input string tag);
    int t = 0;
    logic [2:0] d;
    logic il;
    while (!instr_ready && t < 20) begin @(negedge clk); t++; end
    check({tag, "_ready_before"}, instr_ready, 1);
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    instr = 16'($urandom);
    @(negedge clk); d[2] = done;
    @(negedge clk); d[1] = done;
    @(negedge clk); d[0] = done; il = illegal;
    check({tag, "_done_timing"}, d, 3'b001);
    check({tag, "_illegal"}, il, exp_ill);
    @(negedge clk);
    check({tag, "_ready_after"}, instr_ready, 1);
  endtask

  task automatic check_regs(input string tag);
    for (int a = 0; a < 16; a++) begin
      dbg_addr = 4'(a);
      #1;
      check($sformatf("%s_R%0d", tag, a), dbg_data, (a < NR) ? mr[a] : 0);
    end
  endtask

  function automatic logic [15:0] gen_instr();
    int codes [7] = '{5, 9, 11, 1, 2, 3, 13};
    int sel;
    logic [3:0] rd4, rs4, c4;
    sel = $urandom_range(0, 9);
    rd4 = 4'($urandom_range(0, 8));
    rs4 = 4'($urandom_range(0, 8));
    c4  = 4'(codes[$urandom_range(0, 6)]);
    if (sel == 0) return 16'($urandom);
    if (sel == 1) begin
      if ($urandom_range(0, 1) == 1) return {4'h8, rd4, 4'h4, rs4};
      return {4'h8, rd4, 3'b000, 5'($urandom)};
    end
    if ($urandom_range(0, 1) == 1) return {4'h0, rd4, c4, rs4};
    return {c4, rd4, 8'($urandom)};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ins;
    logic [7:0]  pat;
    logic [3:0]  rd;
    bit          ill;
    bit          seen;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_done", done, 0);
    check("rst_illegal", illegal, 0);
    check("rst_flags", flags, 0);
    check("rst_pc", pc, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", instr_ready, 1);
    model_reset();
    check_regs("rst");

    // Directed table
    add(16'hD17F, 16'h007F, 5'h00, 0);  // MOVI R1,0x7F
    add(16'h5101, 16'h0080, 5'h00, 0);  // ADDI R1,1
    add(16'hD27F, 16'h007F, 5'h00, 0);  // MOVI R2,0x7F
    add(16'h0252, 16'h00FE, 5'h00, 0);  // ADD R2,R2 (doubling)
    add(16'h0252, 16'h01FC, 5'h00, 0);
    add(16'h0252, 16'h03F8, 5'h00, 0);
    add(16'h0252, 16'h07F0, 5'h00, 0);
    add(16'h0252, 16'h0FE0, 5'h00, 0);
    add(16'h0252, 16'h1FC0, 5'h00, 0);
    add(16'h0252, 16'h3F80, 5'h00, 0);
    add(16'h0252, 16'h7F00, 5'h00, 0);
    add(16'h22FF, 16'h7FFF, 5'h00, 0);  // ORI R2,0xFF
    add(16'hD301, 16'h0001, 5'h00, 0);  // MOVI R3,1
    add(16'h0253, 16'h8000, 5'h04, 0);  // ADD R2,R3 -> overflow
    add(16'hD2FF, 16'hFFFF, 5'h04, 0);  // MOVI R2,-1
    add(16'h0253, 16'h0000, 5'h10, 0);  // ADD R2,R3 -> carry
    add(16'hD4FE, 16'hFFFE, 5'h10, 0);  // MOVI R4,0xFE
    add(16'hD501, 16'h0001, 5'h10, 0);  // MOVI R5,1
    add(16'h04B5, 16'hFFFE, 5'h11, 0);  // CMP R4,R5
    add(16'hD603, 16'h0003, 5'h11, 0);  // MOVI R6,3
    add(16'h861F, SHIFTER ? 16'h0001 : 16'h0003, 5'h11, !SHIFTER);  // LSHI R6,-1
    add(16'hD603, 16'h0003, 5'h11, 0);
    add(16'h8604, SHIFTER ? 16'h0030 : 16'h0003, 5'h11, !SHIFTER);  // LSHI R6,+4
    add(16'h0951, 16'h0000, 5'h11, 1);  // ADD R9,R1 -> Rdest out of range
    add(16'h0193, 16'h007F, 5'h01, 0);  // SUB R1,R3
    add(16'h9302, 16'hFFFF, 5'h11, 0);  // SUBI R3,2 -> borrow
    add(16'h0534, 16'hFFFF, 5'h11, 0);  // XOR R5,R4
    add(16'h1580, 16'h0080, 5'h11, 0);  // ANDI R5,0x80 (zero-extended)
    add(16'h0572, 16'h0080, 5'h11, 1);  // undefined ext
    add(16'h5580, 16'h0000, 5'h11, 0);  // ADDI R5,-128 -> carry
    add(16'hD680, 16'hFF80, 5'h11, 0);  // MOVI R6,-128
    add(16'hB17F, 16'h007F, 5'h12, 0);  // CMPI R1,0x7F -> equal
    add(16'hB601, 16'hFF80, 5'h11, 0);  // CMPI R6,1
    add(16'h03B6, 16'hFFFF, 5'h10, 0);  // CMP R3,R6
    add(16'h01B3, 16'h007F, 5'h18, 0);  // CMP R1,R3

    foreach (tbl[i]) begin
      ins = tbl[i].ins;
      rd = ins[11:8];
      run_instr(ins, tbl[i].ill, $sformatf("tbl%0d", i));
      dbg_addr = rd;
      #1;
      check($sformatf("tbl%0d_val", i), dbg_data, tbl[i].val);
      check($sformatf("tbl%0d_flags", i), flags, tbl[i].fl);
      check($sformatf("tbl%0d_pc", i), pc, i + 1);
      @(negedge clk);
    end

    // Reset asserted during EXECUTE of ADDI R1,5
    do_reset();
    instr = 16'h5105;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_done", done, 0);
    check("midrst_pc", pc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | done;
    end
    check("midrst_no_done", seen, 0);
    check("midrst_ready", instr_ready, 1);
    check("midrst_pc_after", pc, 0);
    dbg_addr = 4'd1;
    #1;
    check("midrst_R1", dbg_data, 0);

    // New instr presented while busy must be ignored
    do_reset();
    instr = 16'hD111;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr = 16'hD122;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("busy_done", done, 1);
    instr_valid = 1'b0;
    @(negedge clk);
    dbg_addr = 4'd1;
    #1;
    check("busy_R1", dbg_data, 16'h0011);
    check("busy_pc", pc, 1);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | done;
    end
    check("busy_no_extra", seen, 0);
    check("busy_pc_stable", pc, 1);

    // instr_valid held high: one accept every four cycles
    do_reset();
    instr = 16'h5201;
    instr_valid = 1'b1;
    pat = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      pat = {pat[6:0], done};
      if (k == 7) instr_valid = 1'b0;
    end
    check("b2b_done_pattern", pat, 8'b0010_0010);
    repeat (4) @(negedge clk);
    dbg_addr = 4'd2;
    #1;
    check("b2b_R2", dbg_data, 2);
    check("b2b_pc", pc, 2);

    // Randomized instructions against the reference model
    do_reset();
    model_reset();
    for (int i = 0; i < 150; i++) begin
      ins = gen_instr();
      ill = model_step(ins);
      run_instr(ins, ill, $sformatf("rnd%0d_%h", i, ins));
      check($sformatf("rnd%0d_flags", i), flags, mflags);
      check($sformatf("rnd%0d_pc", i), pc, mpc);
      check_regs($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
